// File: rtl/axil_lsu_param_if.sv
// AXI4-Lite memory port bundle used by the load/store/fetch unit.
// Parameters: ADDR_W address width, DATA_W data width (32 or 64).
// Modports:
//   master - the LSU side: drives AW/W/AR valids, addresses, data, strobes,
//            bready and rready; receives the readies, responses and read data.
//   slave  - the memory side: the mirror image of master.
interface axil_lsu_param_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_lsu_param.sv
// Load/store/fetch unit between the core pipeline and an AXI4-Lite port.
// One request at a time: address = base + offset (base alone for fetch),
// alignment check, AR/R for loads and fetches, AW/W/B for stores with AW
// and W handshaking independently, load lane extraction with zero/sign
// extension, and a one-cycle response pulse with an error code
// (00 ok, 01 misaligned/illegal, 10 bus error, 11 timeout).
// Optional watchdog enabled by defining AXIL_LSU_TIMEOUT_EN; it aborts a
// bus transaction after TO_CYC busy cycles.
// Ports:
//   clock, reset               clock, synchronous active-high reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_op/size/signed         operation, access size, sign-extend loads
//   req_base/offset/wdata      address operands and store data
//   rsp_valid/rsp_data/rsp_err one-cycle completion with result and error
//   bus                        AXI4-Lite master port
module axil_lsu_param #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TO_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  axil_lsu_param_if.master  bus
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LANE_W = (DATA_W == 64) ? 3 : 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_A,
    S_RD_D,
    S_WR,
    S_WR_B,
    S_RESP
  } state_t;

  state_t state;

  logic [LANE_W-1:0] ld_lane;
  logic [1:0]        ld_size;
  logic              ld_sign;
  logic              aw_done;
  logic              w_done;
  logic              busy;
  logic              timeout;

  // Request decode
  logic [ADDR_W-1:0] req_addr;
  logic [LANE_W-1:0] req_lane;
  logic              req_misaligned;
  logic              req_illegal;
  logic [DATA_W-1:0] req_lane_data;
  logic [STRB_W-1:0] req_strb;

  // Fetches address the pc directly; the offset operand is ignored.
  assign req_addr = (req_op == 2'b01) ? req_base : req_base + req_offset;
  assign req_lane = req_addr[LANE_W-1:0];

  always_comb begin
    req_misaligned = 1'b0;
    case (req_size)
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = |req_addr[1:0];
      2'b11:   req_misaligned = (DATA_W == 32) || (|req_addr[2:0]);
      default: req_misaligned = 1'b0;
    endcase
    req_illegal = (req_op == 2'b10) || req_misaligned;
  end

  // Store data is replicated across every lane so the strobe alone selects
  // the bytes written, independent of the address offset.
  always_comb begin
    req_lane_data = '0;
    req_strb      = '0;
    case (req_size)
      2'b00: begin
        for (int unsigned i = 0; i < STRB_W; i++)
          req_lane_data[i*8 +: 8] = req_wdata[7:0];
        req_strb = STRB_W'(1) << req_lane;
      end
      2'b01: begin
        for (int unsigned i = 0; i < STRB_W / 2; i++)
          req_lane_data[i*16 +: 16] = req_wdata[15:0];
        req_strb = STRB_W'(2'b11) << req_lane;
      end
      2'b10: begin
        for (int unsigned i = 0; i < STRB_W / 4; i++)
          req_lane_data[i*32 +: 32] = req_wdata[31:0];
        req_strb = STRB_W'(4'hF) << req_lane;
      end
      default: begin
        req_lane_data = req_wdata;
        req_strb      = '1;
      end
    endcase
  end

  // Load data extraction: shift the addressed lane down, then fill above
  // the access width with zeros or the access sign bit.
  logic [DATA_W-1:0] rd_shifted;
  logic [DATA_W-1:0] ld_data;
  int unsigned       ld_width;

  assign rd_shifted = bus.rdata >> {ld_lane, 3'b000};

  always_comb begin
    case (ld_size)
      2'b00:   ld_width = 8;
      2'b01:   ld_width = 16;
      2'b10:   ld_width = 32;
      default: ld_width = DATA_W;
    endcase
    ld_data = '0;
    for (int unsigned i = 0; i < DATA_W; i++)
      ld_data[i] = (i < ld_width) ? rd_shifted[i]
                                  : (ld_sign & rd_shifted[ld_width-1]);
  end

  assign busy = (state == S_RD_A) || (state == S_RD_D) ||
                (state == S_WR)   || (state == S_WR_B);

`ifdef AXIL_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);
  logic [CNT_W-1:0] wd_cnt;

  // Cleared while idle, so it starts from zero on the accept cycle; the
  // abort fires in the TO_CYC-th busy cycle.
  always_ff @(posedge clock) begin
    if (reset || state == S_IDLE)
      wd_cnt <= '0;
    else if (busy)
      wd_cnt <= wd_cnt + CNT_W'(1);
  end

  assign timeout = busy && (wd_cnt == CNT_W'(TO_CYC - 1));
`else
  localparam int unsigned TO_CYC_UNUSED = TO_CYC;
  assign timeout = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.rresp[0], bus.bresp[0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= '0;
      ld_lane     <= '0;
      ld_size     <= '0;
      ld_sign     <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      bus.awaddr  <= '0;
      bus.awprot  <= '0;
      bus.awvalid <= 1'b0;
      bus.wdata   <= '0;
      bus.wstrb   <= '0;
      bus.wvalid  <= 1'b0;
      bus.bready  <= 1'b0;
      bus.araddr  <= '0;
      bus.arprot  <= '0;
      bus.arvalid <= 1'b0;
      bus.rready  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (timeout) begin
        bus.arvalid <= 1'b0;
        bus.rready  <= 1'b0;
        bus.awvalid <= 1'b0;
        bus.wvalid  <= 1'b0;
        bus.bready  <= 1'b0;
        rsp_valid   <= 1'b1;
        rsp_data    <= '0;
        rsp_err     <= 2'b11;
        state       <= S_RESP;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid && req_ready) begin
              req_ready <= 1'b0;
              ld_lane   <= req_lane;
              ld_size   <= req_size;
              ld_sign   <= req_signed;
              if (req_illegal) begin
                rsp_valid <= 1'b1;
                rsp_data  <= '0;
                rsp_err   <= 2'b01;
                state     <= S_RESP;
              end else if (req_op == 2'b00) begin
                bus.awaddr  <= req_addr;
                bus.awprot  <= 3'b000;
                bus.awvalid <= 1'b1;
                bus.wdata   <= req_lane_data;
                bus.wstrb   <= req_strb;
                bus.wvalid  <= 1'b1;
                aw_done     <= 1'b0;
                w_done      <= 1'b0;
                state       <= S_WR;
              end else begin
                bus.araddr  <= req_addr;
                bus.arprot  <= (req_op == 2'b01) ? 3'b100 : 3'b000;
                bus.arvalid <= 1'b1;
                state       <= S_RD_A;
              end
            end
          end

          S_RD_A: begin
            if (bus.arready) begin
              bus.arvalid <= 1'b0;
              bus.rready  <= 1'b1;
              state       <= S_RD_D;
            end
          end

          S_RD_D: begin
            if (bus.rvalid) begin
              bus.rready <= 1'b0;
              rsp_valid  <= 1'b1;
              rsp_data   <= bus.rresp[1] ? '0 : ld_data;
              rsp_err    <= bus.rresp[1] ? 2'b10 : 2'b00;
              state      <= S_RESP;
            end
          end

          S_WR: begin
            // Each channel finishes on its own handshake; both may complete
            // in the same cycle, or one may already be done from earlier.
            if (bus.awvalid && bus.awready) begin
              bus.awvalid <= 1'b0;
              aw_done     <= 1'b1;
            end
            if (bus.wvalid && bus.wready) begin
              bus.wvalid <= 1'b0;
              w_done     <= 1'b1;
            end
            if ((aw_done || (bus.awvalid && bus.awready)) &&
                (w_done  || (bus.wvalid  && bus.wready))) begin
              bus.bready <= 1'b1;
              state      <= S_WR_B;
            end
          end

          S_WR_B: begin
            if (bus.bvalid) begin
              bus.bready <= 1'b0;
              rsp_valid  <= 1'b1;
              rsp_data   <= '0;
              rsp_err    <= bus.bresp[1] ? 2'b10 : 2'b00;
              state      <= S_RESP;
            end
          end

          S_RESP: begin
            rsp_data  <= '0;
            rsp_err   <= '0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end

          default: begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axil_lsu_param.sv
module tb_axil_lsu_param;

  localparam int WIN = 30;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  axil_lsu_param_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axil_lsu_param #(.ADDR_W(32), .DATA_W(32), .TO_CYC(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_base   (req_base),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observations from the last transaction
  int          o_lat, o_nrsp, o_arv, o_awv, o_wv;
  logic [31:0] o_data, o_araddr, o_awaddr, o_wdata;
  logic [2:0]  o_arprot;
  logic [3:0]  o_wstrb;
  logic [1:0]  o_err;

  task automatic slave_idle();
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rdata   = '0;
    bus.rresp   = '0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = '0;
  endtask

  // Issues one request and plays a slave for a fixed window. Readies are
  // raised once the matching valid has been seen for more than *_wait cycles.
  task automatic run_req(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                         input int ar_wait, input int aw_wait, input int w_wait,
                         input logic [31:0] rd, input logic [1:0] rr, input logic [1:0] br);
    int ar_seen, aw_seen, w_seen;
    ar_seen = 0; aw_seen = 0; w_seen = 0;
    o_lat = 0; o_nrsp = 0; o_arv = 0; o_awv = 0; o_wv = 0;
    o_data = '0; o_err = '0; o_araddr = '0; o_arprot = '0;
    o_awaddr = '0; o_wdata = '0; o_wstrb = '0;
    @(posedge clock); #1;
    req_valid = 1'b1; req_op = op; req_size = size; req_signed = sgn;
    req_base = base; req_offset = off; req_wdata = wd;
    @(posedge clock); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= WIN; c++) begin
      if (rsp_valid) begin
        if (o_nrsp == 0) begin
          o_lat = c; o_data = rsp_data; o_err = rsp_err;
        end
        o_nrsp++;
      end
      if (bus.arvalid) begin
        ar_seen++; o_arv++; o_araddr = bus.araddr; o_arprot = bus.arprot;
      end
      if (bus.awvalid) begin
        aw_seen++; o_awv++; o_awaddr = bus.awaddr;
      end
      if (bus.wvalid) begin
        w_seen++; o_wv++; o_wdata = bus.wdata; o_wstrb = bus.wstrb;
      end
      bus.arready = bus.arvalid && (ar_seen > ar_wait);
      bus.rvalid  = bus.rready;
      bus.rdata   = rd;
      bus.rresp   = rr;
      bus.awready = bus.awvalid && (aw_seen > aw_wait);
      bus.wready  = bus.wvalid && (w_seen > w_wait);
      bus.bvalid  = bus.bready;
      bus.bresp   = br;
      @(posedge clock); #1;
    end
    slave_idle();
  endtask

  int n_rsp;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_op = '0; req_size = '0; req_signed = 1'b0;
    req_base = '0; req_offset = '0; req_wdata = '0;
    slave_idle();
    repeat (3) @(posedge clock);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_awvalid", bus.awvalid, 0);
    check("rst_wvalid", bus.wvalid, 0);
    check("rst_rsp_data", rsp_data, 0);
    reset = 1'b0;

    // Load word, zero-wait slave
    run_req(2'b11, 2'b10, 1'b0, 32'h100, 32'h4, 0, 0, 0, 0, 32'hDEADBEEF, 2'b00, 2'b00);
    check("lw_araddr", o_araddr, 32'h104);
    check("lw_arprot", o_arprot, 3'b000);
    check("lw_lat", o_lat, 3);
    check("lw_data", o_data, 32'hDEADBEEF);
    check("lw_err", o_err, 2'b00);
    check("lw_nrsp", o_nrsp, 1);
    check("lw_ready_after", req_ready, 1);

    // Byte loads signed/unsigned, half signed, byte lane 1
    run_req(2'b11, 2'b00, 1'b1, 32'h100, 32'h3, 0, 0, 0, 0, 32'h80000000, 2'b00, 2'b00);
    check("lb_s_data", o_data, 32'hFFFFFF80);
    run_req(2'b11, 2'b00, 1'b0, 32'h100, 32'h3, 0, 0, 0, 0, 32'h80000000, 2'b00, 2'b00);
    check("lb_u_data", o_data, 32'h00000080);
    run_req(2'b11, 2'b01, 1'b1, 32'h100, 32'h2, 0, 0, 0, 0, 32'h80010000, 2'b00, 2'b00);
    check("lh_s_data", o_data, 32'hFFFF8001);
    run_req(2'b11, 2'b00, 1'b0, 32'h100, 32'h1, 0, 0, 0, 0, 32'h0000A500, 2'b00, 2'b00);
    check("lb_lane1", o_data, 32'h000000A5);

    // Store half, wready 3 cycles before awready
    run_req(2'b00, 2'b01, 1'b0, 32'h200, 32'h2, 32'h1234, 100, 3, 0, 0, 2'b00, 2'b00);
    check("sh_awaddr", o_awaddr, 32'h202);
    check("sh_wstrb", o_wstrb, 4'b1100);
    check("sh_wdata", o_wdata, 32'h12341234);
    check("sh_awv_cycles", o_awv, 4);
    check("sh_wv_cycles", o_wv, 1);
    check("sh_lat", o_lat, 6);
    check("sh_nrsp", o_nrsp, 1);
    check("sh_err", o_err, 2'b00);
    check("sh_data", o_data, 0);

    // Store byte, zero-wait
    run_req(2'b00, 2'b00, 1'b0, 32'h200, 32'h1, 32'hAB, 100, 0, 0, 0, 2'b00, 2'b00);
    check("sb_wstrb", o_wstrb, 4'b0010);
    check("sb_wdata", o_wdata, 32'hABABABAB);
    check("sb_lat", o_lat, 3);

    // Misaligned word load, illegal op, dword on a 32-bit bus
    run_req(2'b11, 2'b10, 1'b0, 32'h100, 32'h1, 0, 0, 0, 0, 32'h12345678, 2'b00, 2'b00);
    check("mis_lat", o_lat, 1);
    check("mis_err", o_err, 2'b01);
    check("mis_arv", o_arv, 0);
    check("mis_nrsp", o_nrsp, 1);
    run_req(2'b10, 2'b10, 1'b0, 32'h100, 32'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    check("illop_err", o_err, 2'b01);
    check("illop_bus", o_arv + o_awv, 0);
    run_req(2'b11, 2'b11, 1'b0, 32'h100, 32'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    check("dword32_err", o_err, 2'b01);

    // Fetch with SLVERR; store with DECERR
    run_req(2'b01, 2'b10, 1'b0, 32'h40, 32'h10, 0, 0, 0, 0, 32'h13, 2'b10, 2'b00);
    check("fetch_araddr", o_araddr, 32'h40);
    check("fetch_arprot", o_arprot, 3'b100);
    check("fetch_err", o_err, 2'b10);
    check("fetch_data", o_data, 0);
    run_req(2'b00, 2'b10, 1'b0, 32'h300, 32'h0, 32'h55, 100, 0, 0, 0, 2'b00, 2'b11);
    check("st_berr", o_err, 2'b10);
    check("st_berr_lat", o_lat, 3);

`ifdef AXIL_LSU_TIMEOUT_EN
    run_req(2'b11, 2'b10, 1'b0, 32'h100, 32'h0, 0, 100, 0, 0, 0, 2'b00, 2'b00);
    check("to_lat", o_lat, 9);
    check("to_err", o_err, 2'b11);
    check("to_arv_cycles", o_arv, 8);
    check("to_nrsp", o_nrsp, 1);
`else
    run_req(2'b11, 2'b10, 1'b0, 32'h100, 32'h0, 0, 15, 0, 0, 32'h77, 2'b00, 2'b00);
    check("slow_lat", o_lat, 18);
    check("slow_err", o_err, 2'b00);
    check("slow_data", o_data, 32'h77);
`endif

    // Reset while waiting for B
    @(posedge clock); #1;
    req_valid = 1'b1; req_op = 2'b00; req_size = 2'b10; req_signed = 1'b0;
    req_base = 32'h400; req_offset = 32'h0; req_wdata = 32'h99;
    @(posedge clock); #1;
    req_valid = 1'b0;
    bus.awready = 1'b1; bus.wready = 1'b1;
    @(posedge clock); #1;
    bus.awready = 1'b0; bus.wready = 1'b0;
    check("wrb_bready", bus.bready, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    n_rsp = 0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid) n_rsp++;
      @(posedge clock); #1;
    end
    check("rst_wrb_nrsp", n_rsp, 0);
    check("rst_wrb_bready", bus.bready, 0);
    check("rst_wrb_ready", req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
